multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port opcode, input, 6, instruction[31:26] from the external IR.
REQ-005 SHALL have port funct, input, 6, instruction[5:0] from the external IR.
REQ-006 SHALL have port zero, input, 1, ALU zero flag.
REQ-007 SHALL have port mem_ready, input, 1, memory completes the current access this cycle.
REQ-008 SHALL have these 1-bit output ports:
  - mem_req: memory access request.
  - mem_we: memory write.
  - iord: memory address source, 0=PC, 1=ALUOut.
  - ir_write: IR load.
  - pc_write: PC load.
  - pc_src: PC source, 0=ALU result, 1=target register.
  - target_write: target register load.
  - reg_write: register-file write.
  - reg_dst: write address source, 1=rd, 0=rt.
  - mem_to_reg: write-back source, 1=MDR.
  - alu_src_a: ALU A source, 0=PC, 1=rs.
  - illegal: unsupported instruction seen.
REQ-009 SHALL have output alu_src_b, 2 bits, ALU B source: 0=rt, 1=constant 4, 2=sign-extended imm, 3=sign-extended imm<<2.
REQ-010 SHALL have output alu_op, 3 bits: 000=add, 100=slt, 110=subtract/compare.
REQ-011 SHALL have output state, 4 bits, current state encoding.
REQ-012 SHALL have output retired, CNT_W bits, count of completed instructions.

Function
REQ-013 SHALL implement these state encodings:
  - RESET=0, FETCH=1, DECODE=2.
  - EXEC_R=3, WB_R=4.
  - ADDR=5, MEM_RD=6, WB_MEM=7, MEM_WR=8.
  - EXEC_I=9, WB_I=10.
  - BRANCH=11, TRAP=12.
REQ-014 SHALL drive all outputs except retired and state as a function of state, with mem_ready as the only other input affecting FETCH; any output not listed for a state SHALL be 0.
REQ-015 RESET: all outputs 0; SHALL go to FETCH next cycle.
REQ-016 FETCH: SHALL drive mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=000.
REQ-017 FETCH: ir_write and pc_write SHALL be 1 only in the cycle mem_ready=1, and the state SHALL then go to DECODE; otherwise the state SHALL stay in FETCH with no limit on wait cycles.
REQ-018 DECODE: SHALL drive target_write=1, alu_src_a=0, alu_src_b=3, alu_op=000.
REQ-019 DECODE next state, by instruction:
  - opcode 0 with funct 0x20 or 0x2A: EXEC_R.
  - opcode 0x23 or 0x2B: ADDR.
  - opcode 8: EXEC_I.
  - opcode 4: BRANCH.
  - anything else, including opcode 0 with any other funct: TRAP.
REQ-020 EXEC_R: SHALL drive alu_src_a=1, alu_src_b=0, alu_op=000 for funct 0x20 and 100 for funct 0x2A; next state WB_R.
REQ-021 WB_R: SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0; next state FETCH.
REQ-022 ADDR: SHALL drive alu_src_a=1, alu_src_b=2, alu_op=000; next state MEM_RD for opcode 0x23, MEM_WR for 0x2B.
REQ-023 MEM_RD: SHALL drive mem_req=1, iord=1; SHALL wait for mem_ready=1, then go to WB_MEM.
REQ-024 WB_MEM: SHALL drive reg_write=1, reg_dst=0, mem_to_reg=1; next state FETCH.
REQ-025 MEM_WR: SHALL drive mem_req=1, mem_we=1, iord=1; SHALL wait for mem_ready=1, then go to FETCH.
REQ-026 EXEC_I: SHALL drive alu_src_a=1, alu_src_b=2, alu_op=000; next state WB_I.
REQ-027 WB_I: SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0; next state FETCH.
REQ-028 BRANCH: SHALL drive alu_src_a=1, alu_src_b=0, alu_op=110, pc_src=1, pc_write=zero; next state FETCH.
REQ-029 TRAP: SHALL drive illegal=1 with all other outputs 0; SHALL stay in TRAP until rst.
REQ-030 retired SHALL increment by 1, wrapping from all-ones to 0, on the final cycle of each instruction: leaving WB_R, WB_MEM, WB_I or BRANCH, and leaving MEM_WR with mem_ready=1.
REQ-031 Latency with zero memory wait SHALL be:
  - add, slt, addi, sw: 4 cycles.
  - lw: 5 cycles.
  - beq: 3 cycles.
  - Each memory wait cycle SHALL add 1 cycle.
REQ-032 mem_ready SHALL be ignored in every state other than FETCH, MEM_RD and MEM_WR.

Reset
REQ-033 rst=1 SHALL immediately force state=RESET and retired=0, regardless of clk and of the current state, including mid-memory-access or TRAP.
REQ-034 After rst is released, the first FETCH SHALL occur on the second rising edge of clk.

Verification
REQ-035 Reset release, add (opcode 0, funct 0x20), mem_ready=1 always -> states 1,2,3,4,1; reg_write=1 and reg_dst=1 only in WB_R; retired=1.
REQ-036 lw (0x23) with mem_ready low for 2 cycles in MEM_RD -> MEM_RD held 3 cycles with mem_req=1 and iord=1; WB_MEM mem_to_reg=1; total 7 cycles.
REQ-037 beq (opcode 4) with zero=1, then with zero=0 -> pc_write=1 and pc_src=1 in BRANCH for the first, pc_write=0 for the second; each instruction 3 cycles.
REQ-038 Opcode 0x3F, then opcode 0 with funct 0x22 -> illegal=1, state=12 held for 10+ cycles, retired unchanged.
REQ-039 rst asserted mid-MEM_WR -> state=0 and mem_req=0 and mem_we=0 without waiting for a clk edge; FETCH 2 edges after release.
REQ-040 CNT_W=2, 4 addi -> retired sequence 1,2,3,0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control unit for a multicycle MIPS-subset datapath (add, slt, lw, sw, addi, beq).
// Moore-style control decode plus a retired-instruction counter.
module multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             target_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic             illegal,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] S_RESET  = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_EXEC_R = 4'd3;
    localparam logic [3:0] S_WB_R   = 4'd4;
    localparam logic [3:0] S_ADDR   = 4'd5;
    localparam logic [3:0] S_MEM_RD = 4'd6;
    localparam logic [3:0] S_WB_MEM = 4'd7;
    localparam logic [3:0] S_MEM_WR = 4'd8;
    localparam logic [3:0] S_EXEC_I = 4'd9;
    localparam logic [3:0] S_WB_I   = 4'd10;
    localparam logic [3:0] S_BRANCH = 4'd11;
    localparam logic [3:0] S_TRAP   = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b110;

    logic [3:0]       state_reg;
    logic [3:0]       state_next;
    logic             hold_reg;
    logic [CNT_W-1:0] retired_reg;
    logic             retire;

    // hold_reg keeps the FSM in RESET for the first edge after rst drops,
    // so FETCH is entered on the second rising edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_RESET;
            hold_reg    <= 1'b1;
            retired_reg <= '0;
        end else begin
            hold_reg  <= 1'b0;
            state_reg <= state_next;
            if (retire) begin
                retired_reg <= retired_reg + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_RESET:  state_next = hold_reg ? S_RESET : S_FETCH;
            S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OP_RTYPE && (funct == FN_ADD || funct == FN_SLT)) begin
                    state_next = S_EXEC_R;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    state_next = S_ADDR;
                end else if (opcode == OP_ADDI) begin
                    state_next = S_EXEC_I;
                end else if (opcode == OP_BEQ) begin
                    state_next = S_BRANCH;
                end else begin
                    state_next = S_TRAP;
                end
            end
            S_EXEC_R: state_next = S_WB_R;
            S_WB_R:   state_next = S_FETCH;
            // Only lw or sw can reach ADDR, so anything but lw is a store.
            S_ADDR:   state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: state_next = mem_ready ? S_WB_MEM : S_MEM_RD;
            S_WB_MEM: state_next = S_FETCH;
            S_MEM_WR: state_next = mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC_I: state_next = S_WB_I;
            S_WB_I:   state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_TRAP;
        endcase
    end

    always_comb begin
        retire = 1'b0;
        case (state_reg)
            S_WB_R, S_WB_MEM, S_WB_I, S_BRANCH: retire = 1'b1;
            S_MEM_WR:                           retire = mem_ready;
            default:                            retire = 1'b0;
        endcase
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        iord         = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        target_write = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src_a    = 1'b0;
        illegal      = 1'b0;
        alu_src_b    = 2'd0;
        alu_op       = ALU_ADD;
        case (state_reg)
            S_FETCH: begin
                mem_req   = 1'b1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                alu_src_b = 2'd1;
            end
            S_DECODE: begin
                target_write = 1'b1;
                alu_src_b    = 2'd3;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = (funct == FN_SLT) ? ALU_SLT : ALU_ADD;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_ADDR, S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            S_WB_I: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = 1'b1;
                pc_write  = zero;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase
    end

    assign state   = state_reg;
    assign retired = retired_reg;

endmodule
